// File: rtl/grid_input_unit_pkg.sv
// Shared definitions for the grid input unit.
//   ipu_state_t  : FSM state encoding (IDLE, DB_PRESS, INT_PEND, WAIT_REL, DB_REL)
//   COORD_W      : width of a cell coordinate, also used by the processor read path
//   MAX_CELL     : highest valid cell index of the 3x3 grid
//   coord_valid  : true when a coordinate addresses a real cell
package grid_input_unit_pkg;

   localparam int COORD_W = 4;
   localparam logic [COORD_W-1:0] MAX_CELL = 4'd8;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      DB_PRESS = 3'd1,
      INT_PEND = 3'd2,
      WAIT_REL = 3'd3,
      DB_REL   = 3'd4
   } ipu_state_t;

   function automatic logic coord_valid(input logic [COORD_W-1:0] c);
      return (c <= MAX_CELL);
   endfunction

endpackage

// File: rtl/grid_input_unit_if.sv
// Processor-side bundle of the grid input unit.
//   ipu_int    : level interrupt request (unit -> processor)
//   int_ack    : interrupt acknowledge   (processor -> unit)
//   grid_coord : latched cell index read by the coordinate-read instruction
//   coord_err  : one-cycle pulse on a press with an out-of-range cell
//   busy       : unit is not idle
// master = the input unit, slave = the processor.
interface grid_input_unit_if;
   import grid_input_unit_pkg::*;

   logic               ipu_int;
   logic               int_ack;
   logic [COORD_W-1:0] grid_coord;
   logic               coord_err;
   logic               busy;

   modport master (
      output ipu_int,
      output grid_coord,
      output coord_err,
      output busy,
      input  int_ack
   );

   modport slave (
      input  ipu_int,
      input  grid_coord,
      input  coord_err,
      input  busy,
      output int_ack
   );
endinterface

// File: rtl/grid_input_unit_sync2.sv
// sync2: parameterized-width two-flop synchronizer for asynchronous inputs.
//   clk     : destination clock
//   rst     : asynchronous active-low reset, loads RST_VAL into both flops
//   d       : asynchronous input
//   q       : synchronized output, two clk edges of latency
module sync2 #(
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] s_p0;
   logic [WIDTH-1:0] s_p1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s_p0 <= RST_VAL;
         s_p1 <= RST_VAL;
      end else begin
         s_p0 <= d;
         s_p1 <= s_p0;
      end
   end

   assign q = s_p1;

endmodule

// File: rtl/grid_input_unit.sv
// grid_input_unit: debounces the board "place" pushbutton, samples the cell
// switches once per accepted press and raises a level interrupt towards the
// processor until it is acknowledged. Each physical press yields at most one
// interrupt; an out-of-range cell yields a coord_err pulse instead.
// Parameters:
//   DEBOUNCE_CYCLES : stable cycles needed to accept a level change
//   CNT_W           : debounce counter width, 2**CNT_W must exceed DEBOUNCE_CYCLES
// Ports:
//   clk         : system clock, rising edge
//   rst         : asynchronous active-low reset
//   btn_place_n : raw pushbutton, low when pressed, asynchronous
//   sw_coord    : raw cell switches, asynchronous
//   cpu         : processor bundle (ipu_int, int_ack, grid_coord, coord_err, busy)
module grid_input_unit
   import grid_input_unit_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                btn_place_n,
   input  logic [COORD_W-1:0]  sw_coord,
   grid_input_unit_if.master   cpu
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic               btn_s;
   logic [COORD_W-1:0] coord_s;
   logic               pressed;

   ipu_state_t         state;
   ipu_state_t         state_nx;
   logic [CNT_W-1:0]   cnt;
   logic               cnt_clr;
   logic               cnt_inc;
   logic               cnt_done;
   logic               coord_load;
   logic               err_pulse;

   logic               ipu_int_q;
   logic [COORD_W-1:0] grid_coord_q;
   logic               coord_err_q;

   // Synchronizer stage: released (1) / zero after reset
   sync2 #(.WIDTH(1), .RST_VAL(1'b1)) u_sync_btn (
      .clk (clk),
      .rst (rst),
      .d   (btn_place_n),
      .q   (btn_s)
   );

   sync2 #(.WIDTH(COORD_W), .RST_VAL('0)) u_sync_coord (
      .clk (clk),
      .rst (rst),
      .d   (sw_coord),
      .q   (coord_s)
   );

   assign pressed  = ~btn_s;
   assign cnt_done = (cnt == CNT_LAST);

   // Control stage: state register, debounce counter and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         cnt          <= '0;
         ipu_int_q    <= 1'b0;
         grid_coord_q <= '0;
         coord_err_q  <= 1'b0;
      end else begin
         state <= state_nx;
         if (cnt_clr) begin
            cnt <= '0;
         end else if (cnt_inc && (cnt != {CNT_W{1'b1}})) begin
            // saturate rather than wrap
            cnt <= cnt + CNT_W'(1);
         end
         // registered so the request is high exactly while in INT_PEND
         ipu_int_q   <= (state_nx == INT_PEND);
         coord_err_q <= err_pulse;
         if (coord_load) begin
            grid_coord_q <= coord_s;
         end
      end
   end

   always_comb begin
      state_nx   = state;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;
      coord_load = 1'b0;
      err_pulse  = 1'b0;
      case (state)
         IDLE: begin
            if (pressed) begin
               state_nx = DB_PRESS;
               cnt_clr  = 1'b1;
            end
         end
         DB_PRESS: begin
            if (!pressed) begin
               state_nx = IDLE;
            end else if (cnt_done) begin
               // switches are sampled only on this completion cycle
               if (coord_valid(coord_s)) begin
                  coord_load = 1'b1;
                  state_nx   = INT_PEND;
               end else begin
                  err_pulse = 1'b1;
                  state_nx  = WAIT_REL;
               end
            end else begin
               cnt_inc = 1'b1;
            end
         end
         INT_PEND: begin
            if (cpu.int_ack) begin
               state_nx = WAIT_REL;
            end
         end
         WAIT_REL: begin
            if (!pressed) begin
               state_nx = DB_REL;
               cnt_clr  = 1'b1;
            end
         end
         DB_REL: begin
            if (pressed) begin
               state_nx = WAIT_REL;
            end else if (cnt_done) begin
               state_nx = IDLE;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   assign cpu.ipu_int    = ipu_int_q;
   assign cpu.grid_coord = grid_coord_q;
   assign cpu.coord_err  = coord_err_q;
   assign cpu.busy       = (state != IDLE);

endmodule

// File: tb/tb_grid_input_unit.sv
// Bench for grid_input_unit with DEBOUNCE_CYCLES=4. A press/release model
// based on run lengths of the synchronized button predicts every output on
// every cycle; directed scenarios are followed by randomized bouncing input.
module tb_grid_input_unit;
   import grid_input_unit_pkg::*;

   localparam int DC = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_place_n = 1'b1;
   logic [3:0] sw_coord = 4'd0;

   grid_input_unit_if ifc ();

   grid_input_unit #(.DEBOUNCE_CYCLES(DC), .CNT_W(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_place_n (btn_place_n),
      .sw_coord    (sw_coord),
      .cpu         (ifc)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // reference model: phase 0 = armed, 1 = interrupt pending, 2 = awaiting release
   int         m_phase;
   int         m_run;
   int         m_rrun;
   logic [3:0] m_coord;
   logic       m_int;
   logic       m_err;
   logic       h_btn [2];
   logic [3:0] h_crd [2];

   int   int_rises;
   int   err_seen;
   logic prev_int;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_phase  = 0;
      m_run    = 0;
      m_rrun   = 0;
      m_coord  = 4'd0;
      m_int    = 1'b0;
      m_err    = 1'b0;
      h_btn[0] = 1'b1;
      h_btn[1] = 1'b1;
      h_crd[0] = 4'd0;
      h_crd[1] = 4'd0;
   endtask

   // one rising edge: the logic acts on raw inputs captured two edges earlier
   task automatic model_edge(input logic ack);
      logic       pr;
      logic [3:0] c;
      pr    = (h_btn[1] == 1'b0);
      c     = h_crd[1];
      m_err = 1'b0;
      case (m_phase)
         0: begin
            if (pr) begin
               m_run++;
               if (m_run == DC + 1) begin
                  m_run = 0;
                  if (c <= 4'd8) begin
                     m_coord = c;
                     m_int   = 1'b1;
                     m_phase = 1;
                  end else begin
                     m_err   = 1'b1;
                     m_phase = 2;
                     m_rrun  = 0;
                  end
               end
            end else begin
               m_run = 0;
            end
         end
         1: begin
            if (ack) begin
               m_int   = 1'b0;
               m_phase = 2;
               m_rrun  = 0;
            end
         end
         default: begin
            if (!pr) begin
               m_rrun++;
               if (m_rrun == DC + 1) begin
                  m_phase = 0;
                  m_run   = 0;
               end
            end else begin
               m_rrun = 0;
            end
         end
      endcase
      h_btn[1] = h_btn[0];
      h_btn[0] = btn_place_n;
      h_crd[1] = h_crd[0];
      h_crd[0] = sw_coord;
   endtask

   task automatic step(input logic b, input logic [3:0] c, input logic a);
      logic exp_busy;
      btn_place_n = b;
      sw_coord    = c;
      ifc.int_ack = a;
      @(posedge clk);
      model_edge(a);
      #1;
      exp_busy = (m_phase != 0) || (m_run > 0);
      chk("ipu_int", 32'(ifc.ipu_int), 32'(m_int));
      chk("grid_coord", 32'(ifc.grid_coord), 32'(m_coord));
      chk("coord_err", 32'(ifc.coord_err), 32'(m_err));
      chk("busy", 32'(ifc.busy), 32'(exp_busy));
      if (ifc.ipu_int === 1'b1 && prev_int !== 1'b1) int_rises++;
      prev_int = ifc.ipu_int;
      if (ifc.coord_err === 1'b1) err_seen++;
   endtask

   // reset asserted away from a clock edge; outputs must clear at once
   task automatic pulse_reset(input string tag);
      rst = 1'b0;
      #1;
      chk({tag, "_int"}, 32'(ifc.ipu_int), 32'd0);
      chk({tag, "_coord"}, 32'(ifc.grid_coord), 32'd0);
      chk({tag, "_err"}, 32'(ifc.coord_err), 32'd0);
      chk({tag, "_busy"}, 32'(ifc.busy), 32'd0);
      model_reset();
      prev_int = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      int lat;
      logic       rb;
      logic [3:0] rc;
      ifc.int_ack = 1'b0;
      model_reset();
      int_rises = 0;
      err_seen  = 0;
      prev_int  = 1'b0;

      #2;
      pulse_reset("reset");

      // valid press on cell 5, acknowledge after ten pressed cycles
      lat = -1;
      int_rises = 0;
      for (int i = 1; i <= 10; i++) begin
         step(1'b0, 4'd5, 1'b0);
         if (ifc.ipu_int === 1'b1 && lat < 0) lat = i - 1;
      end
      chk("int_latency", 32'(lat), 32'(2 + DC));
      chk("coord_5", 32'(ifc.grid_coord), 32'd5);
      step(1'b1, 4'd5, 1'b1);
      chk("ack_drop", 32'(ifc.ipu_int), 32'd0);
      repeat (10) step(1'b1, 4'd5, 1'b0);
      chk("one_int_a", 32'(int_rises), 32'd1);

      // 2-cycle bounce for 20 cycles then released
      int_rises = 0;
      err_seen  = 0;
      for (int i = 0; i < 20; i++) step(((i / 2) % 2) == 1, 4'd2, 1'b0);
      repeat (10) step(1'b1, 4'd2, 1'b0);
      chk("bounce_int", 32'(int_rises), 32'd0);
      chk("bounce_err", 32'(err_seen), 32'd0);

      // out-of-range cell
      int_rises = 0;
      err_seen  = 0;
      repeat (10) step(1'b0, 4'd11, 1'b0);
      repeat (10) step(1'b1, 4'd11, 1'b0);
      chk("bad_err", 32'(err_seen), 32'd1);
      chk("bad_int", 32'(int_rises), 32'd0);
      chk("bad_keep", 32'(ifc.grid_coord), 32'd5);

      // long hold with acknowledge on cycle 20
      int_rises = 0;
      for (int i = 1; i <= 100; i++) step(1'b0, 4'd1, (i == 20));
      chk("hold_one_int", 32'(int_rises), 32'd1);
      chk("hold_busy", 32'(ifc.busy), 32'd1);
      repeat (2 + DC + 1) step(1'b1, 4'd1, 1'b0);
      chk("rel_idle", 32'(ifc.busy), 32'd0);

      // reset in the middle of a pending interrupt, then stray acks
      repeat (8) step(1'b0, 4'd2, 1'b0);
      chk("pend_before_rst", 32'(ifc.ipu_int), 32'd1);
      btn_place_n = 1'b1;
      pulse_reset("rst_pend");
      for (int i = 0; i < 6; i++) step(1'b1, 4'd4, (i % 2) == 0);
      chk("stray_ack", 32'(ifc.busy), 32'd0);

      // cell 3 accepted, switches move to 7 while pending
      repeat (8) step(1'b0, 4'd3, 1'b0);
      repeat (5) step(1'b0, 4'd7, 1'b0);
      chk("coord_hold3", 32'(ifc.grid_coord), 32'd3);
      step(1'b0, 4'd7, 1'b1);
      repeat (4) step(1'b0, 4'd7, 1'b0);
      chk("coord_hold3_after", 32'(ifc.grid_coord), 32'd3);

      // button held through reset counts as a fresh press
      pulse_reset("rst_held");
      int_rises = 0;
      repeat (10) step(1'b0, 4'd6, 1'b0);
      chk("held_reset_int", 32'(int_rises), 32'd1);
      chk("held_reset_coord", 32'(ifc.grid_coord), 32'd6);
      step(1'b0, 4'd6, 1'b1);
      repeat (10) step(1'b1, 4'd6, 1'b0);

      // randomized bouncing button, switch changes and acknowledges
      rc = 4'd0;
      for (int blk = 0; blk < 300; blk++) begin
         int hold;
         hold = $urandom_range(1, 9);
         rb   = 1'($urandom_range(0, 1));
         for (int k = 0; k < hold; k++) begin
            if ($urandom_range(0, 3) == 0) rc = 4'($urandom_range(0, 15));
            step(rb, rc, ($urandom_range(0, 7) == 0));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/grid_input_unit.md
GRID_INPUT_UNIT -- requirements
Module: grid_input_unit

Interface
REQ-001 The unit SHALL have parameter DEBOUNCE_CYCLES, default 500000, giving the number of stable cycles required to accept a button level change (10 ms at 50 MHz).
REQ-002 The unit SHALL have parameter CNT_W, default 20, giving the debounce counter width; it SHALL satisfy 2^CNT_W > DEBOUNCE_CYCLES.
REQ-003 The unit SHALL have port clk, input, 1 bit: the single system clock; all state is clocked on its rising edge.
REQ-004 The unit SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The unit SHALL have port btn_place_n, input, 1 bit: raw board pushbutton, asynchronous to clk, low when pressed.
REQ-006 The unit SHALL have port sw_coord, input, 4 bits: raw switch cell selection, asynchronous to clk, valid cells 0..8.
REQ-007 The unit SHALL have port int_ack, input, 1 bit: processor acknowledge, synchronous to clk, pulse of one or more cycles.
REQ-008 The unit SHALL have port ipu_int, output, 1 bit: level interrupt request to the processor fetch stage.
REQ-009 The unit SHALL have port grid_coord, output, 4 bits: latched cell index read by the processor's coordinate-read instruction.
REQ-010 The unit SHALL have port coord_err, output, 1 bit: one-cycle pulse when a press carries an out-of-range cell.
REQ-011 The unit SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-012 btn_place_n and sw_coord SHALL each pass through a 2-flop synchronizer; all further logic SHALL use only the synchronized values.
REQ-013 The FSM SHALL have states IDLE, DB_PRESS, INT_PEND, WAIT_REL and DB_REL.
REQ-014 IDLE: when the synchronized button reads pressed, the FSM SHALL clear the counter and move to DB_PRESS.
REQ-015 DB_PRESS: the counter SHALL increment each cycle the button stays pressed; a release SHALL return the FSM to IDLE with no output activity.
REQ-016 DB_PRESS: when the counter reaches DEBOUNCE_CYCLES-1 while pressed, the synchronized sw_coord SHALL be sampled that same cycle.
REQ-017 DB_PRESS completion, sampled value <= 8: grid_coord SHALL load that value and the FSM SHALL move to INT_PEND.
REQ-018 DB_PRESS completion, sampled value > 8: coord_err SHALL pulse for 1 cycle, grid_coord SHALL be unchanged and the FSM SHALL move to WAIT_REL.
REQ-019 ipu_int SHALL be registered and SHALL be high exactly while in INT_PEND, asserting on the first INT_PEND cycle.
REQ-020 INT_PEND: int_ack sampled high SHALL move the FSM to WAIT_REL, deasserting ipu_int on the next cycle.
REQ-021 INT_PEND: with no int_ack, the FSM SHALL hold indefinitely with no timeout.
REQ-022 int_ack sampled in any state other than INT_PEND SHALL be ignored.
REQ-023 WAIT_REL: the FSM SHALL wait for the synchronized button to read released, then clear the counter and move to DB_REL.
REQ-024 DB_REL: after DEBOUNCE_CYCLES consecutive released cycles the FSM SHALL move to IDLE; any pressed cycle SHALL return it to WAIT_REL.
REQ-025 Each physical press SHALL produce at most one interrupt; a held button SHALL never re-trigger.
REQ-026 grid_coord SHALL remain stable from load until the next valid accepted press, including after ipu_int falls.
REQ-027 sw_coord changes SHALL have no effect outside the sample cycle of REQ-016.
REQ-028 The counter SHALL saturate and never wrap.

Reset
REQ-029 Asserting rst low SHALL, asynchronously and in any state including INT_PEND mid-handshake, force the FSM to IDLE, ipu_int=0, grid_coord=4'h0, coord_err=0, busy=0, the counter to 0 and the synchronizer flops to the released/zero values.
REQ-030 After rst deasserts, a button already held SHALL be treated as a new press and debounced normally.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, the constant MAX_CELL=4'd8 and the coordinate width 4; the processor coordinate-read path SHALL use the same width constant.
REQ-032 The design SHALL contain one sub-module, sync2, a parameterized-width 2-flop synchronizer instantiated for the button and for the coordinate.

Verification (DEBOUNCE_CYCLES=4)
REQ-033 The bench SHALL cover: sw_coord=5, button pressed for 10 cycles -> ipu_int rises 2+4 cycles after press, grid_coord=5; int_ack pulse -> ipu_int low next cycle.
REQ-034 The bench SHALL cover: button bouncing with 2-cycle pulses for 20 cycles, then released -> no ipu_int and no coord_err.
REQ-035 The bench SHALL cover: sw_coord=11 with a valid press -> one coord_err pulse, no ipu_int, grid_coord retains its previous value of 5.
REQ-036 The bench SHALL cover: button held 100 cycles with int_ack pulsed on cycle 20 -> exactly one interrupt; release plus 4 stable cycles -> busy=0.
REQ-037 The bench SHALL cover: rst low during INT_PEND -> ipu_int=0 and grid_coord=0 immediately; int_ack pulses while IDLE -> no effect.
REQ-038 The bench SHALL cover: sw_coord changes from 3 to 7 during INT_PEND -> grid_coord stays 3.
